arm_dmem_resp: RTL and testbench

ARM_DMEM_RESP -- requirements
Module: arm_dmem_resp

---
 rtl/arm_dmem_pkg.sv | 17 +
 rtl/arm_dmem_array.sv | 31 +++
 rtl/arm_dmem_resp.sv | 149 ++++++++++++++
 tb/tb_arm_dmem_resp.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/arm_dmem_pkg.sv
// rtl/arm_dmem_pkg.sv - shared types and constants for the data-memory responder
package arm_dmem_pkg;

    // Transaction sequencing states of the responder.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Byte lanes per 32-bit word.
    localparam int LANES = 4;

    // Width of the latency down-counter; holds LATENCY-1 for LATENCY up to 15.
    localparam int CNT_W = 4;

endpackage

// File: rtl/arm_dmem_array.sv
// rtl/arm_dmem_array.sv - byte-enabled word storage with registered read port
module arm_dmem_array
    import arm_dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             en,
    input  logic [AW-1:0]    addr,
    input  logic [LANES-1:0] we,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    // Contents are deliberately left uninitialised.
    logic [31:0] mem [DEPTH_WORDS];

    // One access per enable: update the selected lanes and capture the old word.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < LANES; i++) begin
                if (we[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/arm_dmem_resp.sv
// rtl/arm_dmem_resp.sv - fixed-latency data-memory responder (optional ARM_DMEM_ERR_EN out-of-range errors)
module arm_dmem_resp
    import arm_dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [29:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_we,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    logic [29:0]      cap_addr;
    logic [31:0]      cap_wdata;
    logic [3:0]       cap_we;

    logic             accept;
    logic             mem_en;
    logic [29:0]      cur_addr;
    logic [31:0]      cur_wdata;
    logic [3:0]       cur_we;
    logic             cur_err;
    logic [3:0]       mem_we;
    logic [31:0]      mem_rdata;

    logic             resp_is_wr;
    logic             resp_err_q;

    assign req_ready = (state == IDLE);
    assign accept    = req_ready && req_valid && !rst;

    // With LATENCY 1 the array is accessed on the acceptance edge itself, so it
    // must see the live request; otherwise it sees the captured copy.
    assign cur_addr  = (state == IDLE) ? req_addr  : cap_addr;
    assign cur_wdata = (state == IDLE) ? req_wdata : cap_wdata;
    assign cur_we    = (state == IDLE) ? req_we    : cap_we;

`ifdef ARM_DMEM_ERR_EN
    assign cur_err  = ({2'b00, cur_addr} >= 32'(DEPTH_WORDS));
    assign resp_err = resp_valid && resp_err_q;
`else
    logic addr_hi_unused;
    assign addr_hi_unused = ^cur_addr[29:AW];
    assign cur_err  = 1'b0;
    assign resp_err = 1'b0;
`endif

    // The array is touched exactly once, on the edge that enters RESP.
    assign mem_en = (state_nxt == RESP) && !rst;
    assign mem_we = cur_err ? 4'b0000 : cur_we;

    // Next-state and counter logic.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (LATENCY > 1) begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_W'(LATENCY - 1);
                    end else begin
                        state_nxt = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt == CNT_W'(1)) begin
                    state_nxt = RESP;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State and counter registers; reset aborts any outstanding transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Capture the request at acceptance so later input changes are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_we    <= '0;
        end else if (accept) begin
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            cap_we    <= req_we;
        end
    end

    // Remember the kind of access performed for qualifying the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_is_wr <= 1'b0;
            resp_err_q <= 1'b0;
        end else if (mem_en) begin
            resp_is_wr <= |cur_we;
            resp_err_q <= cur_err;
        end
    end

    assign resp_valid = (state == RESP);
    assign resp_rdata = (resp_valid && !resp_is_wr && !resp_err_q) ? mem_rdata : 32'h0;

    arm_dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk   (clk),
        .en    (mem_en),
        .addr  (cur_addr[AW-1:0]),
        .we    (mem_we),
        .wdata (cur_wdata),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_arm_dmem_resp.sv
// tb/tb_arm_dmem_resp.sv - directed self-checking bench for arm_dmem_resp (LATENCY 2, 1, 3)
module tb_arm_dmem_resp;

    logic        clk = 1'b0;
    logic        rst        [3];
    logic        req_valid  [3];
    logic        req_ready  [3];
    logic [29:0] req_addr   [3];
    logic [31:0] req_wdata  [3];
    logic [3:0]  req_we     [3];
    logic        resp_valid [3];
    logic [31:0] resp_rdata [3];
    logic        resp_err   [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Instance 0: LATENCY 2, instance 1: LATENCY 1, instance 2: LATENCY 3.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        arm_dmem_resp #(
            .DEPTH_WORDS (1024),
            .LATENCY     (g == 0 ? 2 : (g == 1 ? 1 : 3))
        ) u_dut (
            .clk        (clk),
            .rst        (rst[g]),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_addr   (req_addr[g]),
            .req_wdata  (req_wdata[g]),
            .req_we     (req_we[g]),
            .resp_valid (resp_valid[g]),
            .resp_rdata (resp_rdata[g]),
            .resp_err   (resp_err[g])
        );
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic txn(input int d, input string tag, input logic [29:0] a, input logic [3:0] we,
                       input logic [31:0] wd, input int exp_lat, input logic [31:0] exp_rd,
                       input logic exp_err);
        int          k;
        bit          got;
        logic [31:0] rd;
        logic        e;
        got = 0;
        rd  = '0;
        e   = 1'b0;
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_addr[d]  = a;
        req_we[d]    = we;
        req_wdata[d] = wd;
        k = 0;
        while (!req_ready[d] && k < 20) begin
            @(negedge clk);
            k++;
        end
        check_val({tag, " ready"}, 32'(req_ready[d]), 32'd1);
        @(negedge clk);
        req_valid[d] = 1'b0;
        req_addr[d]  = 30'h2AB;
        req_we[d]    = 4'hF;
        req_wdata[d] = 32'hFFFF_FFFF;
        k = 1;
        while (k <= 20) begin
            if (resp_valid[d]) begin
                got = 1;
                rd  = resp_rdata[d];
                e   = resp_err[d];
                break;
            end
            @(negedge clk);
            k++;
        end
        check_val({tag, " latency"}, got ? 32'(k) : 32'd0, 32'(exp_lat));
        check_val({tag, " rdata"}, rd, exp_rd);
        check_val({tag, " err"}, 32'(e), 32'(exp_err));
        @(negedge clk);
        check_val({tag, " pulse end"}, {31'd0, resp_valid[d]}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rv_pat;
        logic [7:0] rdy_pat;
        logic       seen;

        for (int d = 0; d < 3; d++) begin
            rst[d]       = 1'b1;
            req_valid[d] = 1'b0;
            req_addr[d]  = '0;
            req_wdata[d] = '0;
            req_we[d]    = '0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check_val("reset ready", 32'(req_ready[d]), 32'd1);
            check_val("reset resp_valid", 32'(resp_valid[d]), 32'd0);
            check_val("reset rdata", resp_rdata[d], 32'd0);
            check_val("reset err", 32'(resp_err[d]), 32'd0);
        end
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;

        // LATENCY 2: basic write then read.
        txn(0, "l2 wr 0x10", 30'h10, 4'b1111, 32'hDEADBEEF, 2, 32'h0, 1'b0);
        txn(0, "l2 rd 0x10", 30'h10, 4'b0000, 32'h0, 2, 32'hDEADBEEF, 1'b0);

        // Byte-lane merge.
        txn(0, "l2 wr 0x20", 30'h20, 4'b1111, 32'h11223344, 2, 32'h0, 1'b0);
        txn(0, "l2 wr lane1", 30'h20, 4'b0010, 32'h0000AA00, 2, 32'h0, 1'b0);
        txn(0, "l2 rd 0x20", 30'h20, 4'b0000, 32'h0, 2, 32'h1122AA44, 1'b0);

        // Out-of-range address handling.
        txn(0, "l2 wr 0x000", 30'h000, 4'b1111, 32'hCAFEF00D, 2, 32'h0, 1'b0);
`ifdef ARM_DMEM_ERR_EN
        txn(0, "l2 rd 0x400", 30'h400, 4'b0000, 32'h0, 2, 32'h0, 1'b1);
        txn(0, "l2 wr 0x400", 30'h400, 4'b1111, 32'h99999999, 2, 32'h0, 1'b1);
        txn(0, "l2 rd 0x000", 30'h000, 4'b0000, 32'h0, 2, 32'hCAFEF00D, 1'b0);
`else
        txn(0, "l2 rd 0x400", 30'h400, 4'b0000, 32'h0, 2, 32'hCAFEF00D, 1'b0);
        txn(0, "l2 wr 0x400", 30'h400, 4'b1111, 32'h99999999, 2, 32'h0, 1'b0);
        txn(0, "l2 rd 0x000", 30'h000, 4'b0000, 32'h0, 2, 32'h99999999, 1'b0);
`endif

        // Request coinciding with reset is dropped.
        @(negedge clk);
        rst[0]       = 1'b1;
        req_valid[0] = 1'b1;
        req_addr[0]  = 30'h10;
        req_we[0]    = 4'b0000;
        @(negedge clk);
        rst[0]       = 1'b0;
        req_valid[0] = 1'b0;
        check_val("rst+valid ready", 32'(req_ready[0]), 32'd1);
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen |= resp_valid[0];
        end
        check_val("rst+valid no resp", 32'(seen), 32'd0);

        // LATENCY 1: write/read through the same-edge access path.
        txn(1, "l1 wr 0x05", 30'h05, 4'b1111, 32'hA5A5A5A5, 1, 32'h0, 1'b0);
        txn(1, "l1 rd 0x05", 30'h05, 4'b0000, 32'h0, 1, 32'hA5A5A5A5, 1'b0);

        // LATENCY 1 back-to-back with req_valid held for 8 cycles.
        @(negedge clk);
        req_valid[1] = 1'b1;
        req_addr[1]  = 30'h05;
        req_we[1]    = 4'b0000;
        rv_pat       = '0;
        rdy_pat      = '0;
        for (int i = 0; i < 8; i++) begin
            rv_pat[i]  = resp_valid[1];
            rdy_pat[i] = req_ready[1];
            if (i < 7) @(negedge clk);
        end
        req_valid[1] = 1'b0;
        check_val("l1 held resp pattern", {24'd0, rv_pat}, 32'h0000_00AA);
        check_val("l1 held ready pattern", {24'd0, rdy_pat}, 32'h0000_0055);
        @(negedge clk);

        // LATENCY 3: reset during WAIT aborts a write.
        txn(2, "l3 wr 0x30", 30'h30, 4'b1111, 32'h12345678, 3, 32'h0, 1'b0);
        @(negedge clk);
        req_valid[2] = 1'b1;
        req_addr[2]  = 30'h30;
        req_we[2]    = 4'b1111;
        req_wdata[2] = 32'h55AA55AA;
        check_val("l3 abort ready", 32'(req_ready[2]), 32'd1);
        @(negedge clk);
        req_valid[2] = 1'b0;
        check_val("l3 abort in wait", 32'(req_ready[2]), 32'd0);
        rst[2] = 1'b1;
        @(negedge clk);
        rst[2] = 1'b0;
        check_val("l3 abort idle", 32'(req_ready[2]), 32'd1);
        seen = resp_valid[2];
        repeat (5) begin
            @(negedge clk);
            seen |= resp_valid[2];
        end
        check_val("l3 abort no resp", 32'(seen), 32'd0);
        txn(2, "l3 rd 0x30", 30'h30, 4'b0000, 32'h0, 3, 32'h12345678, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
